// File: rtl/alu_unit.sv
// ALU execute stage: in-order issue queue feeding one RV32I integer operation per cycle
// into a registered result that drives the ALU lane of the common data bus.
module alu_unit #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             _clear,
    input  logic             _alu_ready,
    input  logic [ROB_W-1:0] _alu_rob_id,
    input  logic [2:0]       _alu_op,
    input  logic             _alu_alt,
    input  logic [31:0]      _alu_v1,
    input  logic [31:0]      _alu_v2,
    output logic             _alu_full,
    input  logic             _cdb_stall,
    output logic             _cdb_ready,
    output logic [ROB_W-1:0] _cdb_rob_id,
    output logic [31:0]      _cdb_value
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [31:0] alu_eval(
        input logic [2:0]  op,
        input logic        alt,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [4:0]         sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        alu_eval = '0;
        case (op)
            3'd0: alu_eval = alt ? (a - b) : (a + b);
            3'd1: alu_eval = a << sh;
            3'd2: alu_eval = {31'd0, (sa < sb)};
            3'd3: alu_eval = {31'd0, (a < b)};
            3'd4: alu_eval = a ^ b;
            3'd5: alu_eval = alt ? $unsigned(sa >>> sh) : (a >> sh);
            3'd6: alu_eval = a | b;
            3'd7: alu_eval = a & b;
            default: alu_eval = '0;
        endcase
    endfunction

    // Issue queue storage (data only, never reset)
    logic [ROB_W-1:0] r_q_tag [DEPTH];
    logic [2:0]       r_q_op  [DEPTH];
    logic             r_q_alt [DEPTH];
    logic [31:0]      r_q_v1  [DEPTH];
    logic [31:0]      r_q_v2  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             r_out_vld_p1;
    logic [ROB_W-1:0] r_out_tag_p1;
    logic [31:0]      r_out_val_p1;

    logic             w_push;
    logic             w_pop;
    logic             w_consume;
    logic             w_flush;
    logic [31:0]      w_head_res;

    assign _alu_full  = rdy_in & (r_count < CNT_W'(DEPTH));
    assign w_flush    = rdy_in & _clear;
    assign w_push     = _alu_ready & _alu_full & ~_clear;
    assign w_consume  = r_out_vld_p1 & ~_cdb_stall & rdy_in;
    // A pop refills the output register on the same edge it drains, so no bubble
    assign w_pop      = rdy_in & ~_clear & (r_count != '0) & (~r_out_vld_p1 | w_consume);
    assign w_head_res = alu_eval(r_q_op[r_rd_ptr], r_q_alt[r_rd_ptr],
                                 r_q_v1[r_rd_ptr], r_q_v2[r_rd_ptr]);

    assign _cdb_ready  = r_out_vld_p1 & rdy_in;
    assign _cdb_rob_id = r_out_tag_p1;
    assign _cdb_value  = r_out_val_p1;

    // Stage p0: queue write
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_q_tag[r_wr_ptr] <= _alu_rob_id;
            r_q_op[r_wr_ptr]  <= _alu_op;
            r_q_alt[r_wr_ptr] <= _alu_alt;
            r_q_v1[r_wr_ptr]  <= _alu_v1;
            r_q_v2[r_wr_ptr]  <= _alu_v2;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Stage p1: result register driving the CDB
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_out_vld_p1 <= 1'b0;
            r_out_tag_p1 <= '0;
            r_out_val_p1 <= '0;
        end else if (w_flush) begin
            r_out_vld_p1 <= 1'b0;
        end else if (w_pop) begin
            r_out_vld_p1 <= 1'b1;
            r_out_tag_p1 <= r_q_tag[r_rd_ptr];
            r_out_val_p1 <= w_head_res;
        end else if (w_consume) begin
            r_out_vld_p1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: a scoreboard queue of expected broadcasts is filled at
// issue time and drained by a CDB monitor; directed checks cover latency, stall, flush, pause, reset.
module tb_alu_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [2:0]  _alu_op;
    logic        _alu_alt;
    logic [31:0] _alu_v1;
    logic [31:0] _alu_v2;
    logic        _alu_full;
    logic        _cdb_stall;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_unit #(.DEPTH(4), .ROB_W(5)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        ._clear      (_clear),
        ._alu_ready  (_alu_ready),
        ._alu_rob_id (_alu_rob_id),
        ._alu_op     (_alu_op),
        ._alu_alt    (_alu_alt),
        ._alu_v1     (_alu_v1),
        ._alu_v2     (_alu_v2),
        ._alu_full   (_alu_full),
        ._cdb_stall  (_cdb_stall),
        ._cdb_ready  (_cdb_ready),
        ._cdb_rob_id (_cdb_rob_id),
        ._cdb_value  (_cdb_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [4:0] tag, input logic [2:0] op, input logic alt,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, output logic acc);
        _alu_ready  = 1'b1;
        _alu_rob_id = tag;
        _alu_op     = op;
        _alu_alt    = alt;
        _alu_v1     = a;
        _alu_v2     = b;
        acc = _alu_full && !_clear;
        if (acc) sb.push_back('{tag: tag, val: exp});
        tick();
        _alu_ready = 1'b0;
    endtask

    // CDB monitor: every completed broadcast must match the oldest outstanding issue
    always @(negedge clk_in) begin
        if (rst_in && _cdb_ready && !_cdb_stall && !_clear) begin
            check("bcast_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("bcast_tag", 32'(_cdb_rob_id), 32'(e.tag));
                check("bcast_val", _cdb_value, e.val);
            end
        end
    end

    initial begin
        logic acc;
        rst_in = 1'b0; rdy_in = 1'b1; _clear = 1'b0; _alu_ready = 1'b0;
        _alu_rob_id = '0; _alu_op = '0; _alu_alt = 1'b0; _alu_v1 = '0; _alu_v2 = '0;
        _cdb_stall = 1'b0;
        #1;
        check("rst_cdb_ready", 32'(_cdb_ready), 32'd0);
        check("rst_rob_id", 32'(_cdb_rob_id), 32'd0);
        check("rst_value", _cdb_value, 32'd0);
        check("rst_alu_full", 32'(_alu_full), 32'd1);
        tick(); tick();
        rst_in = 1'b1;
        tick();

        // Single SUB: two-edge latency, held exactly one cycle
        issue(5'd3, 3'd0, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, acc);
        check("lat_edge1_ready", 32'(_cdb_ready), 32'd0);
        tick();
        check("lat_edge2_ready", 32'(_cdb_ready), 32'd1);
        check("lat_tag", 32'(_cdb_rob_id), 32'd3);
        check("lat_val", _cdb_value, 32'hFFFFFFFE);
        tick();
        check("lat_once", 32'(_cdb_ready), 32'd0);

        // Operator sweep, back to back
        issue(5'd0, 3'd0, 1'b0, 32'h80000000, 32'd1, 32'h80000001, acc);
        issue(5'd1, 3'd0, 1'b1, 32'h80000000, 32'd1, 32'h7FFFFFFF, acc);
        issue(5'd2, 3'd1, 1'b0, 32'h80000000, 32'd1, 32'h00000000, acc);
        issue(5'd3, 3'd2, 1'b0, 32'h80000000, 32'd1, 32'h00000001, acc);
        issue(5'd4, 3'd3, 1'b0, 32'h80000000, 32'd1, 32'h00000000, acc);
        issue(5'd5, 3'd4, 1'b0, 32'h80000000, 32'd1, 32'h80000001, acc);
        issue(5'd6, 3'd5, 1'b0, 32'h80000000, 32'd1, 32'h40000000, acc);
        issue(5'd7, 3'd5, 1'b1, 32'h80000000, 32'd1, 32'hC0000000, acc);
        issue(5'd8, 3'd6, 1'b0, 32'h80000000, 32'd1, 32'h80000001, acc);
        issue(5'd9, 3'd7, 1'b0, 32'h80000000, 32'd1, 32'h00000000, acc);
        // Boundary operands: shamt masking, wraparound, signed vs unsigned compare, alt ignored
        issue(5'd10, 3'd1, 1'b0, 32'd1, 32'h0000003F, 32'h80000000, acc);
        issue(5'd11, 3'd5, 1'b1, 32'hFFFF0000, 32'd4, 32'hFFFFF000, acc);
        issue(5'd12, 3'd2, 1'b0, 32'd5, 32'hFFFFFFFF, 32'd0, acc);
        issue(5'd13, 3'd3, 1'b0, 32'd5, 32'hFFFFFFFF, 32'd1, acc);
        issue(5'd14, 3'd0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd1, acc);
        issue(5'd15, 3'd7, 1'b1, 32'h000000F0, 32'h0000003C, 32'h00000030, acc);
        issue(5'd16, 3'd1, 1'b1, 32'h0000000F, 32'd4, 32'h000000F0, acc);
        for (int i = 0; i < 4; i++) tick();
        check("sweep_drained", 32'(sb.size()), 32'd0);

        // Back-pressure: tag 1 held, 2..5 queued, 6 refused
        _cdb_stall = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            if (t >= 3) begin
                check("stall_hold_ready", 32'(_cdb_ready), 32'd1);
                check("stall_hold_tag", 32'(_cdb_rob_id), 32'd1);
            end
            check("stall_full", 32'(_alu_full), (t <= 5) ? 32'd1 : 32'd0);
            issue(5'(t), 3'd6, 1'b0, 32'(t), 32'h100, 32'(t) | 32'h100, acc);
        end
        check("stall_hold_tag_end", 32'(_cdb_rob_id), 32'd1);
        _cdb_stall = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            check("release_ready", 32'(_cdb_ready), 32'd1);
            check("release_tag", 32'(_cdb_rob_id), 32'(t));
            tick();
        end
        check("release_done", 32'(_cdb_ready), 32'd0);
        check("release_drained", 32'(sb.size()), 32'd0);

        // Flush with a simultaneous issue
        _cdb_stall = 1'b1;
        issue(5'd20, 3'd0, 1'b0, 32'd20, 32'd0, 32'd20, acc);
        issue(5'd21, 3'd0, 1'b0, 32'd21, 32'd0, 32'd21, acc);
        issue(5'd22, 3'd0, 1'b0, 32'd22, 32'd0, 32'd22, acc);
        _clear = 1'b1;
        issue(5'd23, 3'd0, 1'b0, 32'd23, 32'd0, 32'd23, acc);
        _clear = 1'b0;
        sb.delete();
        check("flush_ready", 32'(_cdb_ready), 32'd0);
        check("flush_count", 32'(dut.r_count), 32'd0);
        _cdb_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush_silent", 32'(_cdb_ready), 32'd0);
            tick();
        end

        // Pause with a pending result
        issue(5'd9, 3'd6, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF, acc);
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("pause_ready", 32'(_cdb_ready), 32'd0);
            check("pause_full", 32'(_alu_full), 32'd0);
            tick();
        end
        rdy_in = 1'b1;
        #1;
        check("resume_ready", 32'(_cdb_ready), 32'd1);
        check("resume_tag", 32'(_cdb_rob_id), 32'd9);
        check("resume_val", _cdb_value, 32'h000000FF);
        tick();
        check("resume_once", 32'(_cdb_ready), 32'd0);

        // Asynchronous reset while a result is on the CDB
        _cdb_stall = 1'b1;
        issue(5'd11, 3'd0, 1'b0, 32'd1, 32'd1, 32'd2, acc);
        tick();
        check("rst_mid_pre", 32'(_cdb_ready), 32'd1);
        rst_in = 1'b0;
        #1;
        check("rst_mid_async", 32'(_cdb_ready), 32'd0);
        sb.delete();
        tick();
        rst_in = 1'b1;
        _cdb_stall = 1'b0;
        check("rst_mid_full", 32'(_alu_full), 32'd1);
        check("rst_mid_tag", 32'(_cdb_rob_id), 32'd0);
        check("rst_mid_val", _cdb_value, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_silent", 32'(_cdb_ready), 32'd0);
        end

        check("final_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
